// File: rtl/sp_ram_bist_pkg.sv
// Shared types and the March C- element table for the RAM BIST.
// Holds FSM states, op/element descriptors and the data-pattern helper.
package sp_ram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic is_write;
        logic data_sel;
    } op_t;

    typedef struct packed {
        logic       dir_down;
        logic [1:0] num_ops;
        op_t  [1:0] op;
    } elem_t;

    localparam op_t OP_W0 = '{is_write: 1'b1, data_sel: 1'b0};
    localparam op_t OP_W1 = '{is_write: 1'b1, data_sel: 1'b1};
    localparam op_t OP_R0 = '{is_write: 1'b0, data_sel: 1'b0};
    localparam op_t OP_R1 = '{is_write: 1'b0, data_sel: 1'b1};

    localparam int NUM_ELEMS = 6;

    // Index 0 is M0; op[0] is the first op performed at each address.
    // Single-op elements repeat their op in the unused slot.
    localparam elem_t [NUM_ELEMS-1:0] MARCH_TABLE = {
        elem_t'{dir_down: 1'b0, num_ops: 2'd1, op: {OP_R0, OP_R0}},
        elem_t'{dir_down: 1'b1, num_ops: 2'd2, op: {OP_W0, OP_R1}},
        elem_t'{dir_down: 1'b1, num_ops: 2'd2, op: {OP_W1, OP_R0}},
        elem_t'{dir_down: 1'b0, num_ops: 2'd2, op: {OP_W0, OP_R1}},
        elem_t'{dir_down: 1'b0, num_ops: 2'd2, op: {OP_W1, OP_R0}},
        elem_t'{dir_down: 1'b0, num_ops: 2'd1, op: {OP_W0, OP_W0}}
    };

    function automatic logic [31:0] op_data(op_t op, logic [31:0] bg);
        return op.data_sel ? ~bg : bg;
    endfunction

endpackage

// File: rtl/sp_ram_bist_if.sv
// RAM request/response bundle between the BIST and the RAM port mux.
// master: en/addr/wdata/we/be out, rdata in; slave is the mirror.
interface sp_ram_bist_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                    en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output en, addr, wdata, we, be,
        input  rdata
    );

    modport slave (
        input  en, addr, wdata, we, be,
        output rdata
    );
endinterface

// File: rtl/sp_ram_bist_cmp.sv
// One-stage read-compare pipeline with first-fail capture.
// Ports: clear/flush controls, read request tap, rdata, fail status.
module sp_ram_bist_cmp #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  flush_i,
    input  logic                  rd_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_exp_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [15:0]           fail_count_o
);

    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  mismatch;

    // A flush drops the compare of the read issued last cycle.
    assign mismatch = vld_q && !flush_i && (rdata_i != exp_q);

    always_comb begin
        vld_d   = rd_i && !flush_i;
        exp_d   = rd_exp_i;
        addr_d  = rd_addr_i;
        fail_d  = fail_q;
        faddr_d = faddr_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            vld_d   = 1'b0;
            fail_d  = 1'b0;
            faddr_d = '0;
            cnt_d   = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) faddr_d = addr_q;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q   <= 1'b0;
            exp_q   <= '0;
            addr_q  <= '0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            exp_q   <= exp_d;
            addr_q  <= addr_d;
            fail_q  <= fail_d;
            faddr_q <= faddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fail_o       = fail_q;
    assign fail_addr_o  = faddr_q;
    assign fail_count_o = cnt_q;

endmodule

// File: rtl/sp_ram_bist.sv
// March C- BIST initiator for the single-port RAM, one op per cycle.
// Ports: start/abort in, busy/done/fail status out, RAM bus (master).
module sp_ram_bist
    import sp_ram_bist_pkg::*;
#(
    parameter int                   RAM_SIZE   = 32768,
    parameter int                   ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int                   DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BG_PATTERN = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [15:0]           fail_count_o,
    sp_ram_bist_if.master         ram
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RAM_SIZE / 4 - 1);
    localparam logic [2:0] ELEM_LAST = 3'(NUM_ELEMS - 1);

    state_e            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    elem_t             cur_elem;
    op_t               cur_op;
    logic [2:0]        nxt_elem;
    logic              run, idle_like, last_op, idx_term;
    logic [DATA_WIDTH-1:0] cur_data;

    assign run       = (state_q == ST_RUN);
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy_o    = run || (state_q == ST_DRAIN);
    assign done_o    = (state_q == ST_DONE);

    assign cur_elem = MARCH_TABLE[elem_q];
    assign cur_op   = cur_elem.op[op_q];
    assign cur_data = op_data(cur_op, BG_PATTERN);
    assign nxt_elem = elem_q + 3'd1;
    assign last_op  = ({1'b0, op_q} == cur_elem.num_ops - 2'd1);
    assign idx_term = cur_elem.dir_down ? (idx_q == '0)
                                        : (idx_q == IDX_LAST);

    // Step op, then address, then element.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        op_d    = op_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    elem_d  = '0;
                    op_d    = 1'b0;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (!last_op) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!idx_term) begin
                        idx_d = cur_elem.dir_down ? idx_q - 1'b1
                                                  : idx_q + 1'b1;
                    end else if (elem_q == ELEM_LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        elem_d = nxt_elem;
                        idx_d  = MARCH_TABLE[nxt_elem].dir_down ? IDX_LAST
                                                                : '0;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
        endcase
        if (abort_i && busy_o) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            elem_q  <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
        end
    end

    assign ram.en    = run;
    assign ram.we    = run && cur_op.is_write;
    assign ram.addr  = run ? {idx_q, 2'b00} : '0;
    assign ram.wdata = ram.we ? cur_data : '0;
    assign ram.be    = {(DATA_WIDTH/8){run}};

    sp_ram_bist_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .clk          (clk),
        .rstn_i       (rstn_i),
        .clear_i      (start_i && idle_like),
        .flush_i      (abort_i && busy_o),
        .rd_i         (run && !cur_op.is_write),
        .rd_addr_i    ({idx_q, 2'b00}),
        .rd_exp_i     (cur_data),
        .rdata_i      (ram.rdata),
        .fail_o       (fail_o),
        .fail_addr_o  (fail_addr_o),
        .fail_count_o (fail_count_o)
    );

endmodule
